// File: rtl/request_responder_if.sv
// Request-unit / RAM signal bundle for request_responder.
// The slave modport is the responder's view; master is the requester/RAM side.
interface request_responder_if #(
  parameter int AW = 32
);
  logic          iren;
  logic [AW-1:0] iaddr;
  logic          dren;
  logic          dwen;
  logic [AW-1:0] daddr;
  logic [AW-1:0] dstore;
  logic          ihit;
  logic [AW-1:0] iload;
  logic          dhit;
  logic [AW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [AW-1:0] ramstore;
  logic [AW-1:0] ramload;
  logic          ramready;
  logic          err;

  modport slave (
    input  iren, iaddr, dren, dwen, daddr, dstore, ramload, ramready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iren, iaddr, dren, dwen, daddr, dstore, ramload, ramready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/request_responder.sv
// Memory-side responder: arbitrates fetch vs data requests and runs one
// single-port RAM access at a time, returning one-cycle hit pulses.
module request_responder #(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  request_responder_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef logic [AW-1:0] word_t;
  typedef enum logic [1:0] {IDLE, ACCESS, HIT} state_t;
  typedef enum logic [1:0] {REQ_I, REQ_DR, REQ_DW} req_t;

  state_t        state_q, state_d;
  req_t          req_q, req_d;
  word_t         addr_q, addr_d;
  word_t         store_q, store_d;
  word_t         iload_q, iload_d;
  word_t         dload_q, dload_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic          ihit_q, ihit_d;
  logic          dhit_q, dhit_d;
  logic          err_q, err_d;
  logic          last_data_q, last_data_d;

  logic ipend, dpend, grant_data;

  assign ipend = bus.iren;
  assign dpend = bus.dren | bus.dwen;
  // On a tie the side that did not win last time is served.
  assign grant_data = dpend & ~(ipend & last_data_q);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    store_d     = store_q;
    iload_d     = iload_q;
    dload_d     = dload_q;
    cnt_d       = cnt_q;
    ren_d       = ren_q;
    wen_d       = wen_q;
    err_d       = err_q;
    last_data_d = last_data_q;
    ihit_d      = 1'b0;
    dhit_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ipend | dpend) begin
          last_data_d = grant_data;
          if (grant_data) begin
            req_d  = bus.dwen ? REQ_DW : REQ_DR;
            addr_d = bus.daddr;
            if (bus.dwen) store_d = bus.dstore;
          end else begin
            req_d  = REQ_I;
            addr_d = bus.iaddr;
          end
          ren_d   = ~(grant_data & bus.dwen);
          wen_d   = grant_data & bus.dwen;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.ramready) begin
          if (req_q == REQ_I)  iload_d = bus.ramload;
          if (req_q == REQ_DR) dload_d = bus.ramload;
          ihit_d  = (req_q == REQ_I);
          dhit_d  = (req_q != REQ_I);
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = HIT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Abandon without a hit; the still-held request is re-arbitrated.
          err_d   = 1'b1;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      req_q       <= REQ_I;
      addr_q      <= '0;
      store_q     <= '0;
      iload_q     <= '0;
      dload_q     <= '0;
      cnt_q       <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      ihit_q      <= 1'b0;
      dhit_q      <= 1'b0;
      err_q       <= 1'b0;
      last_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
      cnt_q       <= cnt_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      ihit_q      <= ihit_d;
      dhit_q      <= dhit_d;
      err_q       <= err_d;
      last_data_q <= last_data_d;
    end
  end

  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_request_responder.sv
// Bench for request_responder: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_request_responder;
  localparam int AW      = 32;
  localparam int TIMEOUT = 4;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  request_responder_if #(.AW(AW)) bus ();
  request_responder #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: one outstanding transaction; kind 0=fetch, 1=load, 2=store.
  bit          m_busy, m_hit_owed, m_last_data, m_err;
  int          m_kind, m_waits;
  logic [31:0] m_addr, m_store, m_iload, m_dload;

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_hit_owed = 0; m_last_data = 0; m_err = 0;
    m_kind = 0; m_waits = 0;
    m_addr = '0; m_store = '0; m_iload = '0; m_dload = '0;
  endtask

  // Advance the model across one clock edge using the inputs seen at that edge.
  task automatic model_update();
    bit ip, dp, take_d;
    if (m_hit_owed) begin
      m_hit_owed = 0;
    end else if (m_busy) begin
      if (bus.ramready) begin
        m_busy = 0;
        m_hit_owed = 1;
        if (m_kind == 0) m_iload = bus.ramload;
        if (m_kind == 1) m_dload = bus.ramload;
      end else begin
        m_waits++;
        if (m_waits == TIMEOUT) begin
          m_busy = 0;
          m_err  = 1;
        end
      end
    end else begin
      ip = bus.iren;
      dp = bus.dren | bus.dwen;
      if (ip || dp) begin
        take_d      = dp && !(ip && m_last_data);
        m_last_data = take_d;
        m_kind      = take_d ? (bus.dwen ? 2 : 1) : 0;
        m_addr      = take_d ? bus.daddr : bus.iaddr;
        m_store     = bus.dstore;
        m_waits     = 0;
        m_busy      = 1;
      end
    end
  endtask

  task automatic compare();
    chkb("ramREN", bus.ramREN, m_busy && m_kind != 2);
    chkb("ramWEN", bus.ramWEN, m_busy && m_kind == 2);
    chkb("ihit", bus.ihit, m_hit_owed && m_kind == 0);
    chkb("dhit", bus.dhit, m_hit_owed && m_kind != 0);
    chkb("err", bus.err, m_err);
    chkw("iload", bus.iload, m_iload);
    chkw("dload", bus.dload, m_dload);
    if (m_busy) chkw("ramaddr", bus.ramaddr, m_addr);
    if (m_busy && m_kind == 2) chkw("ramstore", bus.ramstore, m_store);
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    cyc++;
    #1;
    compare();
  endtask

  // Called between edges; assertion takes effect with no clock edge.
  task automatic apply_reset();
    nRST = 1'b0;
    #1;
    chkb("rst_ramREN", bus.ramREN, 1'b0);
    chkb("rst_ramWEN", bus.ramWEN, 1'b0);
    chkb("rst_ihit", bus.ihit, 1'b0);
    chkb("rst_dhit", bus.dhit, 1'b0);
    chkb("rst_err", bus.err, 1'b0);
    chkw("rst_iload", bus.iload, '0);
    chkw("rst_dload", bus.dload, '0);
    chkw("rst_ramaddr", bus.ramaddr, '0);
    chkw("rst_ramstore", bus.ramstore, '0);
    #2;
    nRST = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  task automatic quiet();
    bus.iren = 0; bus.dren = 0; bus.dwen = 0; bus.ramready = 0;
  endtask

  initial begin
    nRST = 1'b1;
    quiet();
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0; bus.ramload = '0;
    model_reset();
    #1;
    apply_reset();

    // Single fetch, zero wait states.
    bus.iren = 1; bus.iaddr = 32'h0000_0040; bus.ramready = 1; bus.ramload = 32'h2021_0001;
    step();
    chkb("fetch_ren_c1", bus.ramREN, 1'b1);
    chkw("fetch_addr_c1", bus.ramaddr, 32'h0000_0040);
    step();
    chkb("fetch_ihit_c2", bus.ihit, 1'b1);
    chkb("fetch_ren_c2", bus.ramREN, 1'b0);
    chkw("fetch_iload", bus.iload, 32'h2021_0001);
    quiet();
    step();

    // Store with three wait states.
    cyc = 0;
    bus.dwen = 1; bus.daddr = 32'h0000_0100; bus.dstore = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      step();
      chkb("store_wen", bus.ramWEN, 1'b1);
      chkb("store_ren", bus.ramREN, 1'b0);
      chkw("store_data", bus.ramstore, 32'hDEAD_BEEF);
      chkb("store_nohit", bus.dhit, 1'b0);
      if (c == 4) bus.ramready = 1;
    end
    step();
    chkb("store_dhit_c5", bus.dhit, 1'b1);
    chkb("store_wen_c5", bus.ramWEN, 1'b0);
    quiet();
    step();

    // Simultaneous requests from reset: data, instruction, data.
    apply_reset();
    bus.iren = 1; bus.iaddr = 32'h80; bus.dren = 1; bus.daddr = 32'h200;
    bus.ramready = 1; bus.ramload = 32'h0BAD_F00D;
    for (int c = 1; c <= 8; c++) begin
      step();
      chkb("tie_ihit", bus.ihit, c == 5);
      chkb("tie_dhit", bus.dhit, c == 2 || c == 8);
    end
    quiet();
    step();
    step();

    // dren and dwen together mean a write.
    cyc = 0;
    bus.dren = 1; bus.dwen = 1; bus.daddr = 32'h300; bus.dstore = 32'h1234_5678;
    step();
    chkb("rw_wen", bus.ramWEN, 1'b1);
    chkb("rw_ren", bus.ramREN, 1'b0);
    bus.ramready = 1;
    step();
    chkb("rw_dhit", bus.dhit, 1'b1);
    quiet();
    step();

    // Timeout with ramready stuck low, then recovery.
    cyc = 0;
    bus.dren = 1; bus.daddr = 32'h400;
    for (int c = 1; c <= 4; c++) begin
      step();
      chkb("to_ren", bus.ramREN, 1'b1);
      chkb("to_err_low", bus.err, 1'b0);
    end
    step();
    chkb("to_err_c5", bus.err, 1'b1);
    chkb("to_ren_c5", bus.ramREN, 1'b0);
    chkb("to_nohit_c5", bus.dhit, 1'b0);
    step();
    chkb("to_retry_c6", bus.ramREN, 1'b1);
    bus.ramready = 1; bus.ramload = 32'hCAFE_0005;
    step();
    chkb("to_dhit_c7", bus.dhit, 1'b1);
    chkb("to_err_c7", bus.err, 1'b1);
    chkw("to_dload", bus.dload, 32'hCAFE_0005);
    quiet();
    step();

    // Reset mid-access, then data must win the first tie.
    bus.iren = 1; bus.iaddr = 32'h500;
    step();
    chkb("ar_ren_before", bus.ramREN, 1'b1);
    apply_reset();
    bus.dren = 1; bus.daddr = 32'h600; bus.ramready = 1; bus.ramload = 32'h7777_0006;
    step();
    chkb("ar_ren_after", bus.ramREN, 1'b1);
    chkw("ar_data_wins", bus.ramaddr, 32'h600);
    step();
    chkb("ar_dhit", bus.dhit, 1'b1);
    chkw("ar_dload", bus.dload, 32'h7777_0006);
    quiet();
    step();

    // Randomized traffic; requesters hold until their hit, occasionally withdraw.
    for (int i = 0; i < 3000; i++) begin
      int r;
      step();
      if (m_hit_owed && m_kind == 0) bus.iren = 0;
      if (m_hit_owed && m_kind != 0) begin bus.dren = 0; bus.dwen = 0; end
      if (m_busy && $urandom_range(0, 29) == 0) begin
        if (m_kind == 0) bus.iren = 0;
        else begin bus.dren = 0; bus.dwen = 0; end
      end
      if (!bus.iren && $urandom_range(0, 2) == 0) bus.iren = 1;
      if (!bus.dren && !bus.dwen && $urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, 2));
        bus.dren = (r != 1);
        bus.dwen = (r != 0);
      end
      bus.iaddr    = $urandom;
      bus.daddr    = $urandom;
      bus.dstore   = $urandom;
      bus.ramload  = $urandom;
      bus.ramready = ($urandom_range(0, 9) < 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
